// File: rtl/root_calc_pkg.sv
// Shared definitions for the root-calculator frame controller.
// - state_e      : frame sequencer states
// - ERR_*        : error codes reported on err_code
// - DEFAULT_HEADER: frame start byte used when the top is not overridden
package root_calc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StCheck,
    StStart,
    StWaitCore,
    StSend,
    StTxWait
  } state_e;

  localparam logic [1:0] ERR_RX_FRAMING = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/root_calc_controller_rx_strobe.sv
// Registered edge detection on the UART receiver flags.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_data     : receiver byte, valid while rx_ready is high
//   rx_ready    : receiver level flag, one rise per byte
//   rx_error    : receiver framing error level flag
//   byte_stb    : one-cycle pulse per rx_ready rise (suppressed by a coincident error rise)
//   err_stb     : one-cycle pulse per rx_error rise
//   byte_data   : byte captured on the rx_ready rise, held until the next one
module rx_strobe_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  output logic       byte_stb,
  output logic       err_stb,
  output logic [7:0] byte_data
);

  logic ready_q;
  logic error_q;
  logic ready_rise;
  logic error_rise;

  assign ready_rise = rx_ready & ~ready_q;
  assign error_rise = rx_error & ~error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      byte_stb  <= 1'b0;
      err_stb   <= 1'b0;
      byte_data <= 8'h00;
    end else begin
      ready_q  <= rx_ready;
      error_q  <= rx_error;
      err_stb  <= error_rise;
      // A byte arriving together with an error is untrustworthy: drop it.
      byte_stb <= ready_rise & ~error_rise;
      if (ready_rise) begin
        byte_data <= rx_data;
      end
    end
  end

endmodule

// File: rtl/root_calc_controller.sv
// Frame sequencer between the UART receiver/transmitter and the root-calculator core.
// Parses HEADER, OPERAND_BYTES radicand bytes (MSB first) and an XOR checksum, starts the
// core, then streams RESULT_BYTES result bytes (MSB first) to the transmitter.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_data/ready/error : UART receiver byte, level ready flag, level error flag
//   core_operand        : radicand, stable from core_start until core_done
//   core_start          : one-cycle start pulse to the core
//   core_done/result    : core completion pulse and root value (valid with core_done)
//   tx_data/start/busy  : transmitter byte, one-cycle send request, busy flag
//   busy                : high whenever the sequencer is not idle
//   err_valid/err_code  : one-cycle error pulse and sticky error code
module root_calc_controller
  import root_calc_pkg::*;
#(
  parameter int unsigned OPERAND_BYTES  = 4,
  parameter int unsigned RESULT_BYTES   = 2,
  parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
  parameter int unsigned TIMEOUT_CYCLES = 520800
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  input  logic                         rx_error,
  output logic [8*OPERAND_BYTES-1:0]   core_operand,
  output logic                         core_start,
  input  logic                         core_done,
  input  logic [8*RESULT_BYTES-1:0]    core_result,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic                         busy,
  output logic                         err_valid,
  output logic [1:0]                   err_code
);

  localparam int unsigned OpW  = 8 * OPERAND_BYTES;
  localparam int unsigned ResW = 8 * RESULT_BYTES;
  localparam int unsigned CntW = $clog2(OPERAND_BYTES) + 1;
  localparam int unsigned IdxW = $clog2(RESULT_BYTES) + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic            byte_stb;
  logic            err_stb;
  logic [7:0]      byte_data;

  state_e          state_q;
  logic [7:0]      chk_q;
  logic [CntW-1:0] cnt_q;
  logic [TmrW-1:0] timer_q;
  logic [ResW-1:0] result_q;
  logic [IdxW-1:0] idx_q;
  logic            busy_seen_q;
  logic [7:0]      res_byte;

  rx_strobe_gen u_rx_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_error  (rx_error),
    .byte_stb  (byte_stb),
    .err_stb   (err_stb),
    .byte_data (byte_data)
  );

  // Result bytes go out MSB first: idx 0 is the top byte.
  always_comb begin
    res_byte = 8'(result_q >> (8 * (RESULT_BYTES - 1 - int'(idx_q))));
  end

  assign busy = (state_q != StIdle);

  // timer_q counts cycles since the last byte strobe. The FSM consumes a strobe one cycle
  // after it rises, so a freshly accepted byte reloads the timer with 1, not 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      core_operand <= '0;
      chk_q        <= 8'h00;
      cnt_q        <= '0;
      timer_q      <= '0;
      result_q     <= '0;
      idx_q        <= '0;
      busy_seen_q  <= 1'b0;
      core_start   <= 1'b0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      err_valid    <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      err_valid  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (byte_stb && (byte_data == HEADER)) begin
            state_q      <= StRecv;
            cnt_q        <= '0;
            chk_q        <= 8'h00;
            timer_q      <= TmrW'(1);
            core_operand <= '0;
          end
        end

        StRecv, StCheck: begin
          if (err_stb) begin
            err_valid <= 1'b1;
            err_code  <= ERR_RX_FRAMING;
            state_q   <= StIdle;
          end else if (byte_stb) begin
            timer_q <= TmrW'(1);
            if (state_q == StRecv) begin
              // HEADER values here are plain data; there is no resync.
              core_operand <= (core_operand << 8) | OpW'(byte_data);
              chk_q        <= chk_q ^ byte_data;
              cnt_q        <= cnt_q + 1'b1;
              if (cnt_q == CntW'(OPERAND_BYTES - 1)) begin
                state_q <= StCheck;
              end
            end else if (byte_data == chk_q) begin
              state_q <= StStart;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_CHECKSUM;
              state_q   <= StIdle;
            end
          end else if (timer_q >= TmrW'(TIMEOUT_CYCLES - 1)) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StStart: begin
          core_start <= 1'b1;
          state_q    <= StWaitCore;
        end

        StWaitCore: begin
          if (core_done) begin
            result_q <= core_result;
            idx_q    <= '0;
            state_q  <= StSend;
          end
        end

        StSend: begin
          if (!tx_busy) begin
            tx_data     <= res_byte;
            tx_start    <= 1'b1;
            busy_seen_q <= 1'b0;
            state_q     <= StTxWait;
          end
        end

        StTxWait: begin
          // Byte is done only after busy has been seen high and then low again.
          if (!busy_seen_q) begin
            if (tx_busy) begin
              busy_seen_q <= 1'b1;
            end
          end else if (!tx_busy) begin
            busy_seen_q <= 1'b0;
            idx_q       <= idx_q + 1'b1;
            if (idx_q == IdxW'(RESULT_BYTES - 1)) begin
              state_q <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
